// File: rtl/latch_readback_serializer.sv
// Snapshots a latch bank on request and shifts it out as a UART-style frame.
// Optional even parity bit enabled by defining LATCH_READBACK_PARITY_EN.
module latch_readback_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] latch_q,
  input  logic             snap_req,
  output logic             snap_ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

`ifdef LATCH_READBACK_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [IW-1:0]    idx, idx_d, idx_nx;
  logic [WIDTH-1:0] shadow, shadow_d;
  logic             tx_d, done_d, ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      tx         <= 1'b1;
      done       <= 1'b0;
      snap_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shadow     <= shadow_d;
      tx         <= tx_d;
      done       <= done_d;
      snap_ready <= ready_d;
      busy       <= ~ready_d;
    end
  end

  // Every branch computes the level tx will hold for the coming bit period,
  // so tx changes on the same edge the state does.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shadow_d = shadow;
    tx_d     = tx;
    done_d   = 1'b0;
    ready_d  = snap_ready;
    idx_nx   = idx + IDX_ONE;
    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (snap_req && snap_ready) begin
          shadow_d = latch_q;
          state_d  = S_START;
          cnt_d    = CNT_MAX;
          idx_d    = '0;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_MAX;
          tx_d    = shadow[0];
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_d = CNT_MAX;
          if (idx == IDX_LAST) begin
`ifdef LATCH_READBACK_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shadow;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_nx;
            tx_d  = shadow[idx_nx];
          end
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
`ifdef LATCH_READBACK_PARITY_EN
      S_PARITY: begin
        if (cnt == '0) begin
          state_d = S_STOP;
          cnt_d   = CNT_MAX;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_latch_readback_serializer.sv
// Randomized bench for latch_readback_serializer against a frame-level reference model.
module tb_latch_readback_serializer;

  localparam int W    = 8;
  localparam int DIVA = 4;
`ifdef LATCH_READBACK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + 2 + PAR;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] latch_q, latch_q_b;
  logic         snap_req, snap_req_b;
  logic         snap_ready, busy, tx, done;
  logic         snap_ready_b, busy_b, tx_b, done_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  latch_readback_serializer #(.WIDTH(W), .DIV(DIVA)) dut_a (
    .clk(clk), .rst_n(rst_n), .latch_q(latch_q), .snap_req(snap_req),
    .snap_ready(snap_ready), .busy(busy), .tx(tx), .done(done)
  );

  latch_readback_serializer #(.WIDTH(W), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .latch_q(latch_q_b), .snap_req(snap_req_b),
    .snap_ready(snap_ready_b), .busy(busy_b), .tx(tx_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Level of the serial line during bit position pos of a frame carrying v.
  function automatic logic model_bit(input logic [W-1:0] v, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= W) return v[pos-1];
    if (PAR == 1 && pos == W + 1) return ^v;
    return 1'b1;
  endfunction

  // One frame on dut_a; optional mid-frame latch change, ignored request pulse, or reset.
  task automatic run_frame(input logic [W-1:0] v, input int tog_at, input logic [W-1:0] tog_v,
                           input int pulse_at, input int rst_at);
    @(posedge clk); #1;
    latch_q  = v;
    snap_req = 1'b1;
    @(negedge clk);
    chk("ready_pre", snap_ready, 1);
    @(posedge clk); #1;
    snap_req = 1'b0;
    for (int c = 0; c < NB * DIVA; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_ready", snap_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        return;
      end
      chk("tx", tx, model_bit(v, c / DIVA));
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      if (c == tog_at) latch_q = tog_v;
      if (c == pulse_at) snap_req = 1'b1;
      else if (c == pulse_at + 1) snap_req = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("ready_post", snap_ready, 1);
    chk("tx_post", tx, 1);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("busy_post", busy, 0);
  endtask

  initial begin
    int bad;
    logic [W-1:0] v1, v2;
    rst_n      = 1'b0;
    snap_req   = 1'b0;
    snap_req_b = 1'b0;
    latch_q    = '0;
    latch_q_b  = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", snap_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tx_b", tx_b, 1);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || snap_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle50", bad, 0);

    run_frame(8'hA5, -1, 8'h00, -1, -1);
    run_frame(8'h07, -1, 8'h00, -1, -1);
    run_frame(8'h3C, 5, 8'hFF, 10, -1);
    for (int i = 0; i < 6; i++) begin
      run_frame(W'($urandom), $urandom_range(0, NB * DIVA - 1), W'($urandom),
                $urandom_range(1, NB * DIVA - 3), -1);
    end

    run_frame(8'h5A, -1, 8'h00, -1, 17);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || snap_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_idle", bad, 0);
    run_frame(8'hC3, -1, 8'h00, -1, -1);

    v1 = W'($urandom);
    v2 = W'($urandom);
    @(posedge clk); #1;
    latch_q_b  = v1;
    snap_req_b = 1'b1;
    @(posedge clk); #1;
    latch_q_b = v2;
    for (int c = 0; c <= 2 * NB; c++) begin
      @(negedge clk);
      if (c < NB) chk("b2b_tx1", tx_b, model_bit(v1, c));
      else if (c == NB) begin
        chk("b2b_gap", tx_b, 1);
        chk("b2b_done", done_b, 1);
        chk("b2b_ready", snap_ready_b, 1);
      end else chk("b2b_tx2", tx_b, model_bit(v2, c - NB - 1));
      if (c == NB + 1) snap_req_b = 1'b0;
    end
    repeat (NB + 3) @(negedge clk);
    chk("b2b_idle_ready", snap_ready_b, 1);
    chk("b2b_idle_tx", tx_b, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
